// File: rtl/ppu_pkg.sv
// Shared PPU definitions: mode encoding and LCD / framebuffer geometry.
// The framebuffer is 2bpp, four pixels per byte, two banks back to back.
package ppu_pkg;

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    V_BLANK = 2'd1,
    SCAN    = 2'd2,
    DRAW    = 2'd3
  } PPU_STATES_t;

  localparam int LCD_W             = 160;
  localparam int LCD_H             = 144;
  localparam int FB_BYTES_PER_LINE = 40;
  localparam int FB_BANK_BYTES     = 5760;
  localparam int FB_ENTRY_W        = 22;

  // y*40 built from shifts: y*32 + y*8
  function automatic logic [13:0] fb_line_base(input logic [7:0] y);
    return {1'b0, y, 5'd0} + {3'd0, y, 3'd0};
  endfunction

endpackage

// File: rtl/ppu_fb_fifo.sv
// Synchronous FIFO of {addr, data} byte-write entries between the packer
// and the framebuffer port. Caller guarantees no push when full without pop.
module ppu_fb_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (i_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  // Extra pointer bit distinguishes full from empty
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/ppu_fb_writer.sv
// PPU pixel-stream sink: packs 2bpp pixels four per byte and writes them
// into a double-buffered framebuffer through a valid/ready byte port.
module ppu_fb_writer
  import ppu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LCD_W      = 160,
  parameter int LCD_H      = 144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PX_OUT,
  input  logic        PX_valid,
  input  logic [1:0]  PPU_MODE,
  output logic        FB_WR,
  input  logic        FB_READY,
  output logic [13:0] FB_ADDR,
  output logic [7:0]  FB_DATA,
  output logic        FB_BANK,
  output logic        FRAME_DONE,
  input  logic        CLR_STATUS,
  output logic [2:0]  STATUS
);

  localparam logic [7:0] X_END = 8'(LCD_W);
  localparam logic [7:0] Y_END = 8'(LCD_H);

  PPU_STATES_t                 w_mode;
  PPU_STATES_t                 r_prev_mode;
  logic [7:0]                  r_x;
  logic [7:0]                  r_y;
  logic [7:0]                  r_byte;
  logic                        r_line_any;
  logic                        r_bank;
  logic                        r_frame_done;
  logic [2:0]                  r_status;
  logic [FB_ENTRY_W-1:0]       r_last;

  logic                        w_accept;
  logic                        w_line_end;
  logic                        w_short;
  logic                        w_flush;
  logic                        w_vblank_entry;
  logic                        w_push_req;
  logic                        w_y_ok;
  logic                        w_fifo_push;
  logic                        w_pop;
  logic                        w_full;
  logic                        w_empty;
  logic [7:0]                  w_packed;
  logic [7:0]                  w_push_data;
  logic [13:0]                 w_addr;
  logic [FB_ENTRY_W-1:0]       w_head;

  assign w_mode = PPU_STATES_t'(PPU_MODE);

  always_comb begin
    w_packed = r_byte;
    case (r_x[1:0])
      2'd0:    w_packed[7:6] = PX_OUT;
      2'd1:    w_packed[5:4] = PX_OUT;
      2'd2:    w_packed[3:2] = PX_OUT;
      default: w_packed[1:0] = PX_OUT;
    endcase
  end

  always_comb begin
    w_accept       = PX_valid && (w_mode == DRAW) && (r_x < X_END);
    w_line_end     = (r_prev_mode == DRAW) && (w_mode == H_BLANK);
    w_short        = w_line_end && r_line_any && (r_x < X_END);
    // A line ending on a byte boundary has nothing left to flush
    w_flush        = w_short && (r_x[1:0] != 2'd0);
    w_vblank_entry = (w_mode == V_BLANK) && (r_prev_mode != V_BLANK);
    w_push_req     = (w_accept && (r_x[1:0] == 2'd3)) || w_flush;
    w_push_data    = w_accept ? w_packed : r_byte;
    w_y_ok         = (r_y < Y_END);
    w_pop          = !w_empty && FB_READY;
    w_fifo_push    = w_push_req && w_y_ok && (!w_full || w_pop);
    w_addr         = (r_bank ? 14'(FB_BANK_BYTES) : 14'd0) + fb_line_base(r_y)
                   + {8'd0, r_x[7:2]};
  end

  ppu_fb_fifo #(
    .WIDTH (FB_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_fifo_push),
    .i_wdata ({w_addr, w_push_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_mode  <= SCAN;
      r_x          <= 8'd0;
      r_y          <= 8'd0;
      r_byte       <= 8'd0;
      r_line_any   <= 1'b0;
      r_bank       <= 1'b0;
      r_frame_done <= 1'b0;
      r_status     <= 3'd0;
      r_last       <= '0;
    end else begin
      r_prev_mode  <= w_mode;
      r_frame_done <= w_vblank_entry;
      if (w_pop) r_last <= w_head;

      if (CLR_STATUS) r_status <= 3'd0;
      else            r_status <= r_status | {w_push_req && !w_y_ok,
                                              w_short,
                                              w_push_req && w_y_ok && w_full && !w_pop};

      // Any partial byte left at V_BLANK belongs to an already-flagged short line
      if (w_vblank_entry) begin
        r_bank     <= ~r_bank;
        r_x        <= 8'd0;
        r_y        <= 8'd0;
        r_byte     <= 8'd0;
        r_line_any <= 1'b0;
      end else if (w_line_end && r_line_any) begin
        r_x        <= 8'd0;
        r_y        <= (r_y == 8'hFF) ? r_y : r_y + 8'd1;
        r_byte     <= 8'd0;
        r_line_any <= 1'b0;
      end else if (w_accept) begin
        r_x        <= r_x + 8'd1;
        r_line_any <= 1'b1;
        r_byte     <= (r_x[1:0] == 2'd3) ? 8'd0 : w_packed;
      end
    end
  end

  assign FB_WR      = !w_empty;
  assign FB_ADDR    = w_empty ? r_last[21:8] : w_head[21:8];
  assign FB_DATA    = w_empty ? r_last[7:0]  : w_head[7:0];
  assign FB_BANK    = r_bank;
  assign FRAME_DONE = r_frame_done;
  assign STATUS     = r_status;

endmodule
